mask_statistics: RTL and testbench
==================================

// Module: mask_statistics
// PURPOSE
// Downstream of background_subtraction. Reads the foreground mask it wrote to SRAM
// (sram_select_in + 1) % 4, one byte per pixel (0x00 bg / 0xFF fg), serially.
// Produces foreground pixel count and bounding box. Results go to the Raspberry Pi host interface.
// PARAMETERS
// IMG_WIDTH   128                    pixels per row (power of two)
// IMG_HEIGHT  128                    rows
// IMG_LENGTH  IMG_WIDTH*IMG_HEIGHT   mask bytes per frame
// PORTS
// clk            in   1            system clock
// rst_n          in   1            async active-low reset
// sram_select_in in   2            base SRAM index; mask SRAM m = (sram_select_in+1)%4
// inst_address   in   24           mask start address in SRAM m
// mem_out        in   4            serial read data, one bit per SRAM
// io_valid       in   4            mem_out bit valid, per SRAM
// rw_done        in   4            transfer complete pulse, per SRAM
// inst           out  8 x [0:3]    SRAM command (0 none, 3 read)
// address        out  24 x [0:3]   SRAM start address
// byte_length    out  24 x [0:3]   SRAM transfer length in bytes
// execute        in   1            start pulse
// job_done       out  1            1-cycle completion pulse
// fg_count       out  $clog2(IMG_LENGTH+1)  foreground pixel count
// min_x,max_x    out  $clog2(IMG_WIDTH)     bbox columns
// min_y,max_y    out  $clog2(IMG_HEIGHT)    bbox rows
// bbox_valid     out  1            at least one foreground pixel in frame
// short_read     out  1            rw_done came before IMG_LENGTH pixels
// BEHAVIOUR
// - Reset: state IDLE; all inst/address/byte_length 0; job_done 0.
//   All result outputs, bbox_valid and short_read are 0. Counters cleared.
// - States:
//   - IDLE: on execute, latch sram_select_in and inst_address, clear accumulators, go to REQ.
//     execute in any other state is ignored.
//   - REQ (1 cycle): drive inst[m]=3, address[m]=latched addr, byte_length[m]=IMG_LENGTH.
//     Go to RECV.
//   - RECV: inst/address/byte_length[m] return to 0.
//     On io_valid[m], shift mem_out[m] MSB-first into an 8-bit register and count bits.
//     On the 8th bit, pixel = (byte != 0), then process pixel index p. p increments per byte.
//     - Bytes after p reaches IMG_LENGTH are ignored.
//     - On rw_done[m], go to DONE. A bit valid in the same cycle as rw_done is counted first.
//   - DONE (1 cycle): publish results atomically, pulse job_done=1, go to IDLE.
// - Per-pixel processing:
//   - x = p % IMG_WIDTH, y = p / IMG_WIDTH; keep x/y counters, no divider.
//   - fg pixel: fg_count+1; min/max x/y updated with <= / >=.
//   - The first fg pixel initialises all four bbox values.
// - Results:
//   - Held unchanged from DONE until the next DONE, including through a new job.
//   - No fg pixel: bbox_valid=0 and min/max = 0.
//   - short_read=1 iff fewer than IMG_LENGTH pixels were completed at rw_done.
//     A partial trailing byte is discarded.
// - Other SRAMs: the three non-m SRAM indices are always driven 0. Their io_valid/rw_done are ignored.
// - rst_n low mid-job: immediate return to IDLE with reset values. No job_done pulse.
// - Latency: job_done is exactly 1 cycle after rw_done[m] is sampled.
// TESTING (bench IMG_WIDTH=8, IMG_HEIGHT=4, IMG_LENGTH=32; serial SRAM model)
// - sel=2, addr=0x100, all-zero mask:
//   -> inst[3]=3 for 1 cycle with address 0x100 and length 32.
//   -> job_done 1 cycle after rw_done; fg_count=0, bbox_valid=0, short_read=0.
// - Single 0xFF at p=13 -> fg_count=1; min_x=max_x=5, min_y=max_y=1; bbox_valid=1.
// - Full 0xFF mask -> fg_count=32; bbox (0,0)-(7,3).
// - fg at p=7 and p=24 -> fg_count=2; min_x=0, max_x=7, min_y=0, max_y=3.
// - rw_done after 20 bytes, fg at p=3 -> short_read=1, fg_count=1; later bytes ignored.
// - execute pulsed during RECV -> ignored.
//   rst_n low mid-RECV -> outputs 0, no job_done; next job completes normally.

Source files
------------

// File: rtl/mask_statistics.sv
// Foreground mask statistics: reads a one-byte-per-pixel mask serially from
// SRAM m = (sram_select_in + 1) % 4 and reports the foreground pixel count
// and the bounding box of the foreground pixels.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | waiting for execute; results from the last job are held
// REQ    | one cycle: issue the read command to SRAM m
// RECV   | assemble serial bits into bytes, accumulate per-pixel stats
// DONE   | one cycle: job_done pulse (results were published on entry)
module mask_statistics #(
  parameter int IMG_WIDTH  = 128,
  parameter int IMG_HEIGHT = 128,
  parameter int IMG_LENGTH = IMG_WIDTH * IMG_HEIGHT
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [1:0]                        sram_select_in,
  input  logic [23:0]                       inst_address,
  input  logic [3:0]                        mem_out,
  input  logic [3:0]                        io_valid,
  input  logic [3:0]                        rw_done,
  output logic [7:0]                        inst        [0:3],
  output logic [23:0]                       address     [0:3],
  output logic [23:0]                       byte_length [0:3],
  input  logic                              execute,
  output logic                              job_done,
  output logic [$clog2(IMG_LENGTH+1)-1:0]   fg_count,
  output logic [$clog2(IMG_WIDTH)-1:0]      min_x,
  output logic [$clog2(IMG_WIDTH)-1:0]      max_x,
  output logic [$clog2(IMG_HEIGHT)-1:0]     min_y,
  output logic [$clog2(IMG_HEIGHT)-1:0]     max_y,
  output logic                              bbox_valid,
  output logic                              short_read
);

  localparam int CW = $clog2(IMG_LENGTH + 1);
  localparam int XW = $clog2(IMG_WIDTH);
  localparam int YW = $clog2(IMG_HEIGHT);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RECV, S_DONE} state_t;

  state_t state, state_nxt;

  logic [1:0]    sel_q;
  logic [23:0]   addr_q;
  logic [1:0]    m;
  logic [6:0]    shift_q, shift_nxt;
  logic [2:0]    bit_cnt, bit_cnt_nxt;
  logic [CW-1:0] pix_cnt, pix_nxt;
  logic [XW-1:0] x_cnt, x_nxt;
  logic [YW-1:0] y_cnt, y_nxt;
  logic [CW-1:0] acc_cnt, acc_cnt_nxt;
  logic [XW-1:0] acc_min_x, acc_min_x_nxt, acc_max_x, acc_max_x_nxt;
  logic [YW-1:0] acc_min_y, acc_min_y_nxt, acc_max_y, acc_max_y_nxt;
  logic          acc_found, acc_found_nxt;
  logic [7:0]    byte_nxt;
  logic          bit_take;
  logic          pix_take;
  logic          finish;

  assign m        = sel_q + 2'd1;
  assign byte_nxt = {shift_q, mem_out[m]};
  assign bit_take = (state == S_RECV) && io_valid[m];
  // A completed byte beyond the frame length is dropped.
  assign pix_take = bit_take && (bit_cnt == 3'd7) && (pix_cnt < CW'(IMG_LENGTH));
  assign finish   = (state == S_RECV) && rw_done[m];

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state and SRAM command outputs; only SRAM m is ever non-zero.
  always_comb begin
    state_nxt = state;
    job_done  = 1'b0;
    for (int k = 0; k < 4; k++) begin
      inst[k]        = 8'd0;
      address[k]     = 24'd0;
      byte_length[k] = 24'd0;
    end
    case (state)
      S_IDLE: if (execute) state_nxt = S_REQ;
      S_REQ: begin
        inst[m]        = 8'd3;
        address[m]     = addr_q;
        byte_length[m] = 24'(IMG_LENGTH);
        state_nxt      = S_RECV;
      end
      S_RECV: if (rw_done[m]) state_nxt = S_DONE;
      S_DONE: begin
        job_done  = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Next values of the byte assembler, pixel position and accumulators.
  // Computed combinationally so a bit arriving with rw_done is included
  // in the results published on that same edge.
  always_comb begin
    shift_nxt     = shift_q;
    bit_cnt_nxt   = bit_cnt;
    pix_nxt       = pix_cnt;
    x_nxt         = x_cnt;
    y_nxt         = y_cnt;
    acc_cnt_nxt   = acc_cnt;
    acc_min_x_nxt = acc_min_x;
    acc_max_x_nxt = acc_max_x;
    acc_min_y_nxt = acc_min_y;
    acc_max_y_nxt = acc_max_y;
    acc_found_nxt = acc_found;
    if (state == S_IDLE && execute) begin
      shift_nxt     = '0;
      bit_cnt_nxt   = '0;
      pix_nxt       = '0;
      x_nxt         = '0;
      y_nxt         = '0;
      acc_cnt_nxt   = '0;
      acc_min_x_nxt = '0;
      acc_max_x_nxt = '0;
      acc_min_y_nxt = '0;
      acc_max_y_nxt = '0;
      acc_found_nxt = 1'b0;
    end else if (bit_take) begin
      shift_nxt   = byte_nxt[6:0];
      bit_cnt_nxt = bit_cnt + 3'd1;
      if (pix_take) begin
        pix_nxt = pix_cnt + 1'b1;
        x_nxt   = x_cnt + 1'b1;
        if (x_cnt == XW'(IMG_WIDTH - 1)) y_nxt = y_cnt + 1'b1;
        if (byte_nxt != 8'd0) begin
          acc_cnt_nxt   = acc_cnt + 1'b1;
          acc_found_nxt = 1'b1;
          if (!acc_found) begin
            acc_min_x_nxt = x_cnt;
            acc_max_x_nxt = x_cnt;
            acc_min_y_nxt = y_cnt;
            acc_max_y_nxt = y_cnt;
          end else begin
            if (x_cnt <= acc_min_x) acc_min_x_nxt = x_cnt;
            if (x_cnt >= acc_max_x) acc_max_x_nxt = x_cnt;
            if (y_cnt <= acc_min_y) acc_min_y_nxt = y_cnt;
            if (y_cnt >= acc_max_y) acc_max_y_nxt = y_cnt;
          end
        end
      end
    end
  end

  // Job parameters latched on execute, plus the working accumulators.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q     <= '0;
      addr_q    <= '0;
      shift_q   <= '0;
      bit_cnt   <= '0;
      pix_cnt   <= '0;
      x_cnt     <= '0;
      y_cnt     <= '0;
      acc_cnt   <= '0;
      acc_min_x <= '0;
      acc_max_x <= '0;
      acc_min_y <= '0;
      acc_max_y <= '0;
      acc_found <= 1'b0;
    end else begin
      if (state == S_IDLE && execute) begin
        sel_q  <= sram_select_in;
        addr_q <= inst_address;
      end
      shift_q   <= shift_nxt;
      bit_cnt   <= bit_cnt_nxt;
      pix_cnt   <= pix_nxt;
      x_cnt     <= x_nxt;
      y_cnt     <= y_nxt;
      acc_cnt   <= acc_cnt_nxt;
      acc_min_x <= acc_min_x_nxt;
      acc_max_x <= acc_max_x_nxt;
      acc_min_y <= acc_min_y_nxt;
      acc_max_y <= acc_max_y_nxt;
      acc_found <= acc_found_nxt;
    end
  end

  // Published results: updated together on the edge that enters DONE and
  // held until the next job finishes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fg_count   <= '0;
      min_x      <= '0;
      max_x      <= '0;
      min_y      <= '0;
      max_y      <= '0;
      bbox_valid <= 1'b0;
      short_read <= 1'b0;
    end else if (finish) begin
      fg_count   <= acc_cnt_nxt;
      min_x      <= acc_min_x_nxt;
      max_x      <= acc_max_x_nxt;
      min_y      <= acc_min_y_nxt;
      max_y      <= acc_max_y_nxt;
      bbox_valid <= acc_found_nxt;
      short_read <= (pix_nxt < CW'(IMG_LENGTH));
    end
  end

endmodule

// File: tb/tb_mask_statistics.sv
// Bench for mask_statistics: drives serial SRAM read traffic for random and
// directed masks, checks requests and results through a scoreboard.
module tb_mask_statistics;
  localparam int W = 8;
  localparam int H = 4;
  localparam int L = W * H;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  sram_select_in = '0;
  logic [23:0] inst_address = '0;
  logic [3:0]  mem_out = '0;
  logic [3:0]  io_valid = '0;
  logic [3:0]  rw_done = '0;
  logic [7:0]  inst [0:3];
  logic [23:0] address [0:3];
  logic [23:0] byte_length [0:3];
  logic        execute = 1'b0;
  logic        job_done;
  logic [5:0]  fg_count;
  logic [2:0]  min_x, max_x;
  logic [1:0]  min_y, max_y;
  logic        bbox_valid, short_read;

  mask_statistics #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clk(clk), .rst_n(rst_n), .sram_select_in(sram_select_in),
    .inst_address(inst_address), .mem_out(mem_out), .io_valid(io_valid),
    .rw_done(rw_done), .inst(inst), .address(address), .byte_length(byte_length),
    .execute(execute), .job_done(job_done), .fg_count(fg_count),
    .min_x(min_x), .max_x(max_x), .min_y(min_y), .max_y(max_y),
    .bbox_valid(bbox_valid), .short_read(short_read)
  );

  always #5 clk = ~clk;

  typedef struct { int fg; int mnx; int mxx; int mny; int mxy; bit bv; bit sr; int done_cyc; } res_t;
  typedef struct { int m; int addr; } req_t;

  res_t res_q[$];
  req_t req_q[$];
  res_t prev;
  int   mb[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: pixels in raster order, x = p mod W, y = p div W.
  function automatic res_t model(input int bytes[$]);
    res_t r;
    int n;
    r = '{default: 0};
    n = (bytes.size() < L) ? bytes.size() : L;
    for (int p = 0; p < n; p++) begin
      if (bytes[p] != 0) begin
        int x;
        int y;
        x = p % W;
        y = p / W;
        if (!r.bv) begin
          r.mnx = x; r.mxx = x; r.mny = y; r.mxy = y; r.bv = 1'b1;
        end else begin
          if (x < r.mnx) r.mnx = x;
          if (x > r.mxx) r.mxx = x;
          if (y < r.mny) r.mny = y;
          if (y > r.mxy) r.mxy = y;
        end
        r.fg++;
      end
    end
    r.sr = (bytes.size() < L);
    return r;
  endfunction

  // Request monitor: every non-zero command slot must match a queued request.
  always @(negedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (inst[k] != 0 || address[k] != 0 || byte_length[k] != 0) begin
        if (req_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_req: sram %0d inst %0d addr %0h, none expected", k, inst[k], address[k]);
        end else begin
          req_t r;
          r = req_q.pop_front();
          chk("req_sram", k, r.m);
          chk("req_inst", int'(inst[k]), 3);
          chk("req_addr", int'(address[k]), r.addr);
          chk("req_len", int'(byte_length[k]), L);
        end
      end
    end
  end

  // Result monitor: each job_done pops and compares one expected result.
  always @(negedge clk) begin
    if (job_done) begin
      if (res_q.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL unexpected_job_done: pulse at cycle %0d, none expected", cyc);
      end else begin
        res_t e;
        e = res_q.pop_front();
        chk("done_latency", cyc, e.done_cyc);
        chk("fg_count", int'(fg_count), e.fg);
        chk("min_x", int'(min_x), e.mnx);
        chk("max_x", int'(max_x), e.mxx);
        chk("min_y", int'(min_y), e.mny);
        chk("max_y", int'(max_y), e.mxy);
        chk("bbox_valid", int'(bbox_valid), int'(e.bv));
        chk("short_read", int'(short_read), int'(e.sr));
      end
    end
  end

  task automatic run_job(input int sel, input int addr, input int bytes[$], input int extra_bits,
                         input bit done_with_last, input bit exec_mid, input bit noise, input bit abort);
    int   m;
    bit   bits[$];
    res_t e;
    bit   got;
    m = (sel + 1) % 4;
    e = model(bytes);
    if (!abort) res_q.push_back(e);
    req_q.push_back('{m: m, addr: addr});
    foreach (bytes[i]) for (int b = 7; b >= 0; b--) bits.push_back(((bytes[i] >> b) & 1) != 0);
    for (int j = 0; j < extra_bits; j++) bits.push_back(1'($urandom_range(0, 1)));

    @(negedge clk);
    execute = 1'b1; sram_select_in = 2'(sel); inst_address = 24'(addr);
    @(negedge clk);
    execute = 1'b0; sram_select_in = 2'($urandom); inst_address = 24'($urandom);
    @(negedge clk);
    chk("hold_fg_count", int'(fg_count), prev.fg);
    chk("hold_bbox_valid", int'(bbox_valid), int'(prev.bv));
    chk("hold_max_y", int'(max_y), prev.mxy);
    chk("hold_short_read", int'(short_read), int'(prev.sr));

    foreach (bits[i]) begin
      if (noise) begin
        io_valid = 4'($urandom); mem_out = 4'($urandom); rw_done = 4'($urandom);
        io_valid[m] = 1'b0; rw_done[m] = 1'b0;
        if ($urandom_range(0, 2) == 0) @(negedge clk);
      end
      io_valid[m] = 1'b1;
      mem_out[m]  = bits[i];
      if (exec_mid && i == 12) begin
        execute = 1'b1; sram_select_in = 2'(sel + 1); inst_address = 24'h0ABCDE;
      end
      if (done_with_last && i == bits.size() - 1) begin
        rw_done[m] = 1'b1;
        res_q[res_q.size() - 1].done_cyc = cyc + 1;
      end
      if (abort && i == 40) begin
        #2 rst_n = 1'b0;
        #1;
        chk("rst_job_done", int'(job_done), 0);
        chk("rst_fg_count", int'(fg_count), 0);
        chk("rst_bbox_valid", int'(bbox_valid), 0);
        chk("rst_max_x", int'(max_x), 0);
        chk("rst_inst", int'(inst[m]), 0);
        execute = 1'b0; io_valid = '0; mem_out = '0; rw_done = '0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        prev = '{default: 0};
        repeat (4) @(negedge clk);
        return;
      end
      @(negedge clk);
      execute = 1'b0; io_valid = '0; mem_out = '0; rw_done = '0;
    end

    if (!done_with_last) begin
      rw_done[m] = 1'b1;
      res_q[res_q.size() - 1].done_cyc = cyc + 1;
      @(negedge clk);
      rw_done = '0;
    end
    // Traffic after completion must not disturb anything.
    repeat (8) begin
      io_valid[m] = 1'b1; mem_out[m] = 1'b1;
      @(negedge clk);
    end
    io_valid = '0; mem_out = '0;

    got = 1'b0;
    for (int t = 0; t < 12; t++) begin
      if (res_q.size() == 0) begin got = 1'b1; break; end
      @(negedge clk); #1;
    end
    chk("job_done_seen", int'(got), 1);
    if (!got) res_q.delete();
    prev = e;
  endtask

  task automatic fill(input int n, input int val);
    mb.delete();
    for (int i = 0; i < n; i++) mb.push_back(val);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    prev = '{default: 0};
    repeat (3) @(negedge clk);
    chk("reset_job_done", int'(job_done), 0);
    chk("reset_fg_count", int'(fg_count), 0);
    chk("reset_bbox_valid", int'(bbox_valid), 0);
    chk("reset_short_read", int'(short_read), 0);
    for (int k = 0; k < 4; k++) chk("reset_inst", int'(inst[k]) + int'(address[k]) + int'(byte_length[k]), 0);
    rst_n = 1'b1;
    @(negedge clk);

    fill(L, 0);                     run_job(2, 'h100, mb, 0, 0, 0, 0, 0);
    fill(L, 0); mb[13] = 'hFF;      run_job(0, 'h2000, mb, 0, 0, 0, 0, 0);
    fill(L, 'hFF);                  run_job(1, 'h3456, mb, 0, 0, 0, 0, 0);
    fill(L, 0); mb[7] = 'hFF; mb[24] = 'hFF;
                                    run_job(3, 'h000010, mb, 0, 1, 0, 0, 0);
    fill(20, 0); mb[3] = 'hFF;      run_job(2, 'h40, mb, 5, 0, 0, 0, 0);
    fill(34, 0); mb[31] = 'h01; mb[32] = 'hFF; mb[33] = 'hFF;
                                    run_job(1, 'hFFFFFF, mb, 0, 0, 0, 0, 0);
    fill(L, 0); mb[0] = 'hFF; mb[18] = 'h10;
                                    run_job(2, 'h777, mb, 0, 0, 1, 0, 0);
    fill(L, 'hFF);                  run_job(0, 'h888, mb, 0, 0, 0, 0, 1);
    fill(L, 0); mb[9] = 'h80;       run_job(0, 'h999, mb, 0, 0, 0, 0, 0);

    for (int j = 0; j < 12; j++) begin
      int n;
      n = ($urandom_range(0, 2) == 0) ? int'($urandom_range(L - 8, L + 2)) : L;
      mb.delete();
      for (int i = 0; i < n; i++) begin
        case ($urandom_range(0, 4))
          1: mb.push_back('hFF);
          2: mb.push_back(int'($urandom_range(0, 255)));
          default: mb.push_back(0);
        endcase
      end
      run_job(int'($urandom_range(0, 3)), int'($urandom_range(0, 'hFFFFFF)), mb,
              int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1, 1'b0);
    end

    repeat (5) @(negedge clk);
    chk("end_no_pending_req", req_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
